div_seq: RTL

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_pkg.sv | 19 +
 rtl/cla_add.sv | 42 ++++
 rtl/div_step.sv | 35 +++
 rtl/div_seq.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing helpers for the sequential divider.
package div_pkg;

  // Controller states of div_seq.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // The iteration counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Counter width for the default 8-bit divider.
  localparam int DIV_CNT_W_DEFAULT = cnt_width(8);

endpackage

// File: rtl/cla_add.sv
// cla_add: N-bit carry-lookahead adder. Each carry is built directly from the
// generate/propagate terms and the carry-in, not from the previous sum bit.
module cla_add #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_gp
      assign g[gi] = a[gi] & b[gi];
      assign p[gi] = a[gi] ^ b[gi];
    end
  endgenerate

  // Lookahead carries: c[i] = g[i-1] | p[i-1]&g[i-2] | ... | p[i-1..0]&cin.
  always_comb begin
    logic acc;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i <= N; i++) begin
      acc = cin;
      for (int j = 0; j < i; j++) begin
        acc = g[j] | (p[j] & acc);
      end
      c[i] = acc;
    end
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration. Shifts the next
// dividend bit into the partial remainder, trial-subtracts the divisor on a
// WIDTH+1 bit adder (a + ~b + 1), and keeps or restores the remainder.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           no_borrow;
  logic           unused_diff_msb;

  assign shifted = {rem_in, quo_in[WIDTH-1]};

  cla_add #(.N(WIDTH + 1)) u_sub (
    .a    (shifted),
    .b    (~{1'b0, divisor}),
    .cin  (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  // A kept difference is below the divisor, so its top bit is always zero.
  assign unused_diff_msb = diff[WIDTH];

  assign rem_out = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], no_borrow};

endmodule

// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per clock.
// Unsigned by default; define DIV_SEQ_SIGNED_EN for two's-complement operands
// (magnitudes are divided and signs fixed up when the outputs are loaded).
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             exception
);

  localparam int               CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  div_state_t       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic             zero_reg;

  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             exc_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .quo_in  (quo_reg),
    .divisor (dvs_reg),
    .rem_out (rem_next),
    .quo_out (quo_next)
  );

`ifdef DIV_SEQ_SIGNED_EN
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic dvd_neg;
  logic dvs_neg;
  logic neg_q_reg;
  logic neg_r_reg;
  logic ovf_reg;

  assign dvd_neg = dividend[WIDTH-1];
  assign dvs_neg = divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~dividend + ONE) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + ONE) : divisor;
  assign q_fix   = neg_q_reg ? (~quo_reg + ONE) : quo_reg;
  assign r_fix   = neg_r_reg ? (~rem_reg + ONE) : rem_reg;
  assign exc_fix = zero_reg | ovf_reg;

  // Sign bookkeeping captured with the operands; cleared for divide-by-zero
  // so the raw dividend passes through to the remainder untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (ready && start) begin
      neg_q_reg <= (divisor != '0) && (dvd_neg ^ dvs_neg);
      neg_r_reg <= (divisor != '0) && dvd_neg;
      ovf_reg   <= (dividend == MOST_NEG) && (divisor == ALL_ONES);
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fix   = quo_reg;
  assign r_fix   = rem_reg;
  assign exc_fix = zero_reg;
`endif

  // Controller, working registers and registered result outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      ready        <= 1'b1;
      result_valid <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      exception    <= 1'b0;
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      dvs_reg      <= '0;
      zero_reg     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (state_reg == RUN) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        cnt_reg <= cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_reg <= DONE;
          ready     <= 1'b1;
        end
      end else begin
        // Leaving DONE publishes the finished result for one cycle.
        if (state_reg == DONE) begin
          quotient     <= q_fix;
          remainder    <= r_fix;
          exception    <= exc_fix;
          result_valid <= 1'b1;
        end
        if (start) begin
          if (divisor == '0) begin
            state_reg <= DONE;
            zero_reg  <= 1'b1;
            quo_reg   <= ALL_ONES;
            rem_reg   <= dividend;
            cnt_reg   <= '0;
          end else begin
            state_reg <= RUN;
            ready     <= 1'b0;
            zero_reg  <= 1'b0;
            quo_reg   <= dvd_mag;
            rem_reg   <= '0;
            dvs_reg   <= dvs_mag;
            cnt_reg   <= CNT_LOAD;
          end
        end else begin
          state_reg <= IDLE;
        end
      end
    end
  end

endmodule
